// File: rtl/konata_retire_arbiter_if.sv
// Retire-event bus between the per-source writeback taps and the trace serializer.
// Signal names are written from the arbiter's point of view (_i into it, _o out of it).
interface konata_retire_arbiter_if #(
   parameter int N_SRC = 8,
   parameter int ID_W  = 64
);
   localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   logic [N_SRC-1:0]      src_valid_i;
   logic [N_SRC*ID_W-1:0] src_id_i;
   logic                  evt_valid_o;
   logic [SRC_W-1:0]      evt_src_o;
   logic [ID_W-1:0]       evt_id_o;
   logic                  evt_ready_i;

   modport slave (
      input  src_valid_i, src_id_i, evt_ready_i,
      output evt_valid_o, evt_src_o, evt_id_o
   );

   modport master (
      output src_valid_i, src_id_i, evt_ready_i,
      input  evt_valid_o, evt_src_o, evt_id_o
   );
endinterface

// File: rtl/konata_retire_arbiter.sv
// Serializes per-cycle multi-source retire events into a single ordered event stream.
// Each cycle's events form one queue row; rows drain lowest source index first.
module konata_retire_arbiter #(
   parameter int N_SRC = 8,
   parameter int DEPTH = 4,
   parameter int ID_W  = 64
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     enable_i,
   input  logic                     flush_i,
   konata_retire_arbiter_if.slave   bus,
   output logic                     busy_o,
   output logic                     overflow_o,
   output logic [15:0]              drop_cnt_o
);
   localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   function automatic logic [SRC_W-1:0] lowest_set(input logic [N_SRC-1:0] m);
      logic [SRC_W-1:0] idx;
      idx = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (m[k]) idx = SRC_W'(k);
      end
      return idx;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [N_SRC-1:0]      mask_q [DEPTH];
   logic [N_SRC-1:0]      mask_d [DEPTH];
   logic                  overflow_q, overflow_d;
   logic [15:0]           drop_cnt_q, drop_cnt_d;
   logic [N_SRC*ID_W-1:0] id_q [DEPTH];

   logic [N_SRC-1:0]      head_mask;
   logic [N_SRC-1:0]      head_bit;
   logic [N_SRC-1:0]      head_rem;
   logic [SRC_W-1:0]      head_src;
   logic                  evt_valid;
   logic                  xfer;
   logic                  pop;
   logic                  push_req;
   logic                  accept;

   assign head_mask = mask_q[rd_ptr_q];
   assign head_src  = lowest_set(head_mask);
   assign head_bit  = N_SRC'(1) << head_src;
   assign head_rem  = head_mask & ~head_bit;
   assign evt_valid = (count_q != '0);

   // Flush gates both sides so that nothing moves on a flush edge.
   assign xfer     = evt_valid && bus.evt_ready_i && !flush_i;
   assign pop      = xfer && (head_rem == '0);
   assign push_req = enable_i && !flush_i && (bus.src_valid_i != '0);
   assign accept   = push_req && ((count_q != CNT_FULL) || pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      mask_d     = mask_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;

      if (flush_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else begin
         if (xfer) mask_d[rd_ptr_q] = head_rem;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         // When full with a pop, wr_ptr equals rd_ptr, so this overwrites the row just retired.
         if (accept) begin
            mask_d[wr_ptr_q] = bus.src_valid_i;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
         end
         case ({accept, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         if (push_req && !accept) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc16(drop_cnt_q);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mask_q[i] <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         mask_q     <= mask_d;
      end
   end

   // Id payload is qualified by the masks, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (accept) id_q[wr_ptr_q] <= bus.src_id_i;
   end

   assign bus.evt_valid_o = evt_valid;
   assign bus.evt_src_o   = head_src;
   assign bus.evt_id_o    = id_q[rd_ptr_q][int'(head_src) * ID_W +: ID_W];

   assign busy_o     = evt_valid;
   assign overflow_o = overflow_q;
   assign drop_cnt_o = drop_cnt_q;
endmodule

// File: tb/tb_konata_retire_arbiter.sv
// Directed-vector bench for konata_retire_arbiter (N_SRC=8, DEPTH=4, ID_W=64).
module tb_konata_retire_arbiter;
   logic        clk;
   logic        rstn;
   logic        enable;
   logic        flush;
   logic        busy;
   logic        overflow;
   logic [15:0] drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   konata_retire_arbiter_if #(.N_SRC(8), .ID_W(64)) bus ();

   konata_retire_arbiter #(.N_SRC(8), .DEPTH(4), .ID_W(64)) dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .enable_i   (enable),
      .flush_i    (flush),
      .bus        (bus),
      .busy_o     (busy),
      .overflow_o (overflow),
      .drop_cnt_o (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, wanted finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_src();
      bus.src_valid_i = '0;
      bus.src_id_i    = '0;
   endtask

   task automatic set_src(input int k, input logic [63:0] id);
      bus.src_valid_i[k]       = 1'b1;
      bus.src_id_i[k*64 +: 64] = id;
   endtask

   task automatic expect_evt(input string tag, input int s, input logic [63:0] id);
      check_val({tag, ".vld"}, 64'(bus.evt_valid_o), 64'd1);
      check_val({tag, ".src"}, 64'(bus.evt_src_o), 64'(s));
      check_val({tag, ".id"},  bus.evt_id_o, id);
      tick();
   endtask

   initial begin
      rstn            = 1'b0;
      enable          = 1'b0;
      flush           = 1'b0;
      bus.evt_ready_i = 1'b0;
      clr_src();
      #1;
      check_val("rst.vld",  64'(bus.evt_valid_o), 64'd0);
      check_val("rst.busy", 64'(busy), 64'd0);
      check_val("rst.ovf",  64'(overflow), 64'd0);
      check_val("rst.drop", 64'(drop_cnt), 64'd0);
      repeat (2) @(negedge clk);
      rstn   = 1'b1;
      enable = 1'b1;
      tick();

      // Single event, and no combinational path from inputs to the event port
      bus.evt_ready_i = 1'b1;
      set_src(2, 64'h10);
      #1;
      check_val("single.nobypass", 64'(bus.evt_valid_o), 64'd0);
      tick();
      clr_src();
      expect_evt("single", 2, 64'h10);
      check_val("single.busy", 64'(busy), 64'd0);

      // Multi-source row drains in ascending index
      set_src(0, 64'hA);
      set_src(1, 64'hB);
      set_src(7, 64'hC);
      tick();
      clr_src();
      expect_evt("multi0", 0, 64'hA);
      expect_evt("multi1", 1, 64'hB);
      check_val("multi.busy_before_last", 64'(busy), 64'd1);
      expect_evt("multi7", 7, 64'hC);
      check_val("multi.busy", 64'(busy), 64'd0);

      // Backpressure: head held stable while new rows arrive
      bus.evt_ready_i = 1'b0;
      set_src(3, 64'h33);
      tick();
      for (int i = 0; i < 5; i++) begin
         clr_src();
         case (i)
            0: set_src(0, 64'h40);
            1: set_src(5, 64'h55);
            2: begin set_src(0, 64'h60); set_src(7, 64'h67); end
            default: ;
         endcase
         check_val($sformatf("bp.hold%0d.src", i), 64'(bus.evt_src_o), 64'd3);
         check_val($sformatf("bp.hold%0d.id", i),  bus.evt_id_o, 64'h33);
         tick();
      end
      clr_src();
      bus.evt_ready_i = 1'b1;
      expect_evt("bp.e0", 3, 64'h33);
      expect_evt("bp.e1", 0, 64'h40);
      expect_evt("bp.e2", 5, 64'h55);
      expect_evt("bp.e3", 0, 64'h60);
      expect_evt("bp.e4", 7, 64'h67);
      check_val("bp.busy", 64'(busy), 64'd0);
      check_val("bp.drop", 64'(drop_cnt), 64'd0);

      // Overflow: six pushes into four rows, two dropped
      bus.evt_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         clr_src();
         set_src(i, 64'h100 + 64'(i));
         tick();
      end
      clr_src();
      check_val("ovf.busy", 64'(busy), 64'd1);
      check_val("ovf.flag", 64'(overflow), 64'd1);
      check_val("ovf.drop", 64'(drop_cnt), 64'd2);
      bus.evt_ready_i = 1'b1;
      expect_evt("ovf.e0", 0, 64'h100);
      expect_evt("ovf.e1", 1, 64'h101);
      expect_evt("ovf.e2", 2, 64'h102);
      expect_evt("ovf.e3", 3, 64'h103);
      check_val("ovf.empty", 64'(busy), 64'd0);
      check_val("ovf.sticky", 64'(overflow), 64'd1);

      // Full queue with a pop on the same edge as a push
      bus.evt_ready_i = 1'b0;
      set_src(0, 64'h200);
      set_src(1, 64'h201);
      tick();
      for (int j = 0; j < 3; j++) begin
         clr_src();
         set_src(4 + j, 64'h210 + 64'(j));
         tick();
      end
      clr_src();
      bus.evt_ready_i = 1'b1;
      expect_evt("full.e0", 0, 64'h200);
      check_val("full.head.src", 64'(bus.evt_src_o), 64'd1);
      check_val("full.head.id",  bus.evt_id_o, 64'h201);
      set_src(7, 64'h2FF);
      tick();
      clr_src();
      check_val("full.drop", 64'(drop_cnt), 64'd2);
      expect_evt("full.e1", 4, 64'h210);
      expect_evt("full.e2", 5, 64'h211);
      expect_evt("full.e3", 6, 64'h212);
      expect_evt("full.e4", 7, 64'h2FF);
      check_val("full.empty", 64'(busy), 64'd0);

      // Flush empties the queue and clears the drop counters
      bus.evt_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         clr_src();
         set_src(i, 64'h300 + 64'(i));
         tick();
      end
      clr_src();
      check_val("flush.pre_busy", 64'(busy), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_val("flush.vld",  64'(bus.evt_valid_o), 64'd0);
      check_val("flush.busy", 64'(busy), 64'd0);
      check_val("flush.ovf",  64'(overflow), 64'd0);
      check_val("flush.drop", 64'(drop_cnt), 64'd0);

      // Flush suppresses a push on the same edge
      flush = 1'b1;
      bus.evt_ready_i = 1'b1;
      set_src(2, 64'h3A);
      tick();
      flush = 1'b0;
      clr_src();
      check_val("flush.push_suppressed", 64'(busy), 64'd0);

      // Enable low: no capture, no drop
      enable = 1'b0;
      set_src(1, 64'h3B);
      tick();
      clr_src();
      check_val("en_off.busy", 64'(busy), 64'd0);
      check_val("en_off.drop", 64'(drop_cnt), 64'd0);
      enable = 1'b1;

      // Lowering enable keeps draining
      bus.evt_ready_i = 1'b0;
      set_src(6, 64'h3C);
      tick();
      clr_src();
      set_src(2, 64'h3D);
      tick();
      clr_src();
      enable = 1'b0;
      bus.evt_ready_i = 1'b1;
      expect_evt("drain.e0", 6, 64'h3C);
      expect_evt("drain.e1", 2, 64'h3D);
      check_val("drain.empty", 64'(busy), 64'd0);
      enable = 1'b1;

      // Asynchronous reset in the middle of a drain
      bus.evt_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         clr_src();
         set_src(i, 64'h400 + 64'(i));
         tick();
      end
      clr_src();
      check_val("arst.pre_drop", 64'(drop_cnt), 64'd2);
      bus.evt_ready_i = 1'b1;
      expect_evt("arst.e0", 0, 64'h400);
      rstn = 1'b0;
      #1;
      check_val("arst.vld",  64'(bus.evt_valid_o), 64'd0);
      check_val("arst.busy", 64'(busy), 64'd0);
      check_val("arst.ovf",  64'(overflow), 64'd0);
      check_val("arst.drop", 64'(drop_cnt), 64'd0);
      #2;
      rstn = 1'b1;
      tick();
      check_val("arst.post_vld", 64'(bus.evt_valid_o), 64'd0);
      check_val("arst.post_busy", 64'(busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/konata_retire_arbiter.md
KONATA_RETIRE_ARBITER -- requirements
Module: konata_retire_arbiter

Interface
REQ-001 Parameter N_SRC, default 8: number of retire-event sources (wb1..wb4, wb1_fp, wb2_fp, wb1_simd, wb2_simd/store).
REQ-002 Parameter DEPTH, default 4: number of queue rows; power of two, minimum 2.
REQ-003 Parameter ID_W, default 64: width of the instruction trace id.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous and active-low.
REQ-006 enable_i  input  1  trace enable; events are captured only while high.
REQ-007 flush_i  input  1  synchronous clear of queue contents.
REQ-008 src_valid_i  input  N_SRC  per-source retire-event valid for the current cycle.
REQ-009 src_id_i  input  N_SRC*ID_W  per-source trace id; source k occupies bits [k*ID_W +: ID_W].
REQ-010 evt_valid_o  output  1  serialized event available.
REQ-011 evt_src_o  output  clog2(N_SRC)  source index of the presented event.
REQ-012 evt_id_o  output  ID_W  trace id of the presented event.
REQ-013 evt_ready_i  input  1  consumer (trace-dump model) accepts the event.
REQ-014 busy_o  output  1  queue non-empty.
REQ-015 overflow_o  output  1  sticky flag: at least one row dropped since reset or flush.
REQ-016 drop_cnt_o  output  16  saturating count of dropped rows.

Function
REQ-017 A row is {mask[N_SRC], id[N_SRC][ID_W]}; the queue is a circular buffer of DEPTH rows with wr_ptr, rd_ptr and count (0..DEPTH).
REQ-018 Push: in any cycle with enable_i=1, flush_i=0 and src_valid_i!=0, one row {src_valid_i, src_id_i} is written at wr_ptr if it is accepted.
REQ-019 Cycles with src_valid_i==0 or enable_i=0 push nothing and do not count as drops.
REQ-020 Output: evt_valid_o=1 iff count!=0; evt_src_o = index of the lowest set bit of the head row mask; evt_id_o = the head row id at that index.
REQ-021 Handshake: an event transfers when evt_valid_o=1 and evt_ready_i=1; the transferred bit is cleared from the head mask on that edge.
REQ-022 When the transferred bit is the last set bit of the head mask, the row is popped (rd_ptr advances, count decrements) on the same edge.
REQ-023 evt_src_o and evt_id_o remain stable while evt_valid_o=1 and evt_ready_i=0; pushes never modify the head row.
REQ-024 Latency: an event pushed at edge N is presentable at the earliest in the cycle after edge N; there is no combinational bypass from src_*_i to evt_*_o.
REQ-025 Within a row, events are emitted in ascending source index; rows are emitted in push order.
REQ-026 A push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs on the same edge.
REQ-027 A push that is not accepted is dropped whole: overflow_o is set, drop_cnt_o increments and saturates at 16'hFFFF, and queue contents are unchanged.
REQ-028 A simultaneous push and pop leaves count unchanged; pointers wrap modulo DEPTH.
REQ-029 flush_i=1 empties the queue (count=0, pointers=0), clears overflow_o and drop_cnt_o, and suppresses both push and pop in that cycle; flush_i has priority over all other operations.
REQ-030 Lowering enable_i does not stop draining; already-queued rows are still emitted.

Reset
REQ-031 While rstn_i=0, regardless of the clock: count=0, wr_ptr=rd_ptr=0, all masks=0, evt_valid_o=0, busy_o=0, overflow_o=0, drop_cnt_o=0.
REQ-032 Asserting reset mid-drain discards all queued events; no event is emitted in the first cycle after deassertion.
REQ-033 id storage does not require reset; evt_id_o and evt_src_o are don't-care while evt_valid_o=0.

Verification
REQ-034 Single event: src_valid_i=8'b0000_0100, id 0x10, ready=1 -> next cycle evt_valid_o=1, src=2, id=0x10; one cycle later busy_o=0.
REQ-035 Multi-source row: mask 8'b1000_0011, ids 0xA/0xB/0xC, ready=1 -> three consecutive events with src 0,1,7; the row pops on the third edge.
REQ-036 Backpressure: row with src 3 present, ready=0 for 5 cycles while new rows arrive -> src/id held constant; ordering is preserved after ready=1.
REQ-037 Overflow: ready=0, 6 consecutive nonzero pushes with DEPTH=4 -> count=4, overflow_o=1, drop_cnt_o=2; 4 rows are then drained in order.
REQ-038 Full with simultaneous pop: count=4, head row has 1 bit left, ready=1 and a push on the same edge -> push accepted, count stays 4, drop_cnt_o unchanged.
REQ-039 Flush/reset: queue holding 3 rows with flush_i=1 -> evt_valid_o=0 the next cycle and counters cleared; same stimulus with rstn_i pulsed low between edges -> outputs at reset values immediately.
